// File: rtl/instr_mem_ctrl_if.sv
// Fetch, response and program-load signals shared between the fetch stage and the instruction memory.
// The master drives requests and loads; the slave is the memory controller.
interface instr_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       instr;
    logic              fault_mis;
    logic              fault_rng;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              busy;

    modport master (
        output req_valid, pc, rsp_ready, ld_we, ld_addr, ld_data,
        input  req_ready, rsp_valid, instr, fault_mis, fault_rng, busy
    );

    modport slave (
        input  req_valid, pc, rsp_ready, ld_we, ld_addr, ld_data,
        output req_ready, rsp_valid, instr, fault_mis, fault_rng, busy
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Writable big-endian instruction memory with a registered valid/ready fetch port,
// a word-wide program-load port and a hardware clear sequence after reset.
//
// state | meaning
// ------+------------------------------------------------------------
// CLEAR | writing INIT_WORD to word clr_idx each cycle; no fetch/load
// RUN   | fetches and program loads serviced; left only via reset
module instr_mem_ctrl #(
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH_BYTES = 64,
    parameter logic [31:0] INIT_WORD   = 32'h0000_0000
) (
    input logic             clk,
    input logic             reset,
    instr_mem_ctrl_if.slave bus
);
    localparam int NW = DEPTH_BYTES / 4;
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int IW = AW - 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_BYTES - 4);
    localparam logic [IW-1:0]     LAST_IDX  = IW'(NW - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] clr_idx;
    logic [31:0]   mem [NW];

    logic          rsp_valid_q;
    logic [31:0]   instr_q;
    logic          mis_q;
    logic          rng_q;

    logic          req_ready_c;
    logic          accept;
    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [31:0]   mem_wdata;
    logic          pc_mis;
    logic          pc_rng;
    logic          ld_ok;
    logic          unused_ld_lsb;

    assign pc_mis = |bus.pc[1:0];
    assign pc_rng = bus.pc > LAST_ADDR;
    // Load address low bits are don't-care, so the range test uses the word-aligned address.
    assign ld_ok  = {bus.ld_addr[ADDR_W-1:2], 2'b00} <= LAST_ADDR;
    assign unused_ld_lsb = ^bus.ld_addr[1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        mem_we      = 1'b0;
        mem_idx     = clr_idx;
        mem_wdata   = INIT_WORD;
        case (state)
            CLEAR: begin
                mem_we = 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A load blocks the fetch port for the cycle so the two never collide on the array.
                req_ready_c = ~bus.ld_we & (~rsp_valid_q | bus.rsp_ready);
                if (bus.ld_we && ld_ok) begin
                    mem_we    = 1'b1;
                    mem_idx   = bus.ld_addr[AW-1:2];
                    mem_wdata = bus.ld_data;
                end
            end
        endcase
    end

    assign accept = bus.req_valid & req_ready_c;

    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            instr_q     <= '0;
            mis_q       <= 1'b0;
            rng_q       <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            instr_q     <= (pc_mis || pc_rng) ? 32'h0 : mem[bus.pc[AW-1:2]];
            mis_q       <= pc_mis;
            rng_q       <= pc_rng;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.instr     = instr_q;
    assign bus.fault_mis = mis_q;
    assign bus.fault_rng = rng_q;
    assign bus.busy      = (state == CLEAR);
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed and randomized bench for instr_mem_ctrl against a byte-array reference model.
module tb_instr_mem_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    instr_mem_ctrl_if #(.ADDR_W(32)) bus();

    instr_mem_ctrl #(
        .ADDR_W(32),
        .DEPTH_BYTES(64),
        .INIT_WORD(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: 64 bytes, big-endian, plus the last response the consumer should see.
    logic [7:0]  mb [64];
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic        m_mis = 1'b0;
    logic        m_rng = 1'b0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mword(input logic [31:0] a);
        logic [5:0] b;
        b = a[5:0];
        return {mb[b], mb[b + 6'd1], mb[b + 6'd2], mb[b + 6'd3]};
    endfunction

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.pc        = '0;
        bus.rsp_ready = 1'b1;
        bus.ld_we     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
    endtask

    task automatic apply_reset(input int n);
        idle();
        reset = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset   = 1'b1;
        m_valid = 1'b0;
        m_instr = '0;
        m_mis   = 1'b0;
        m_rng   = 1'b0;
    endtask

    // Counts busy cycles while hammering the fetch and load ports, which must be ignored.
    task automatic wait_clear();
        int cnt;
        cnt = 0;
        bus.req_valid = 1'b1;
        bus.pc        = '0;
        bus.rsp_ready = 1'b0;
        bus.ld_we     = 1'b1;
        bus.ld_addr   = '0;
        bus.ld_data   = 32'hFFFF_FFFF;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cnt++;
            check("clr_req_ready", 32'(bus.req_ready), 32'h0);
            check("clr_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        end
        idle();
        check("clear_len", 32'(cnt), 32'd16);
        for (int i = 0; i < 64; i++) mb[i] = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rv, input logic [31:0] p, input logic rr,
                        input logic lw, input logic [31:0] la, input logic [31:0] ld);
        logic        exp_ready;
        logic [31:0] wa;
        bus.req_valid = rv;
        bus.pc        = p;
        bus.rsp_ready = rr;
        bus.ld_we     = lw;
        bus.ld_addr   = la;
        bus.ld_data   = ld;
        @(negedge clk);
        exp_ready = !lw && (!m_valid || rr);
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
        check("instr", bus.instr, m_instr);
        check("fault_mis", 32'(bus.fault_mis), 32'(m_mis));
        check("fault_rng", 32'(bus.fault_rng), 32'(m_rng));
        check("busy_run", 32'(bus.busy), 32'h0);
        wa = {la[31:2], 2'b00};
        if (lw && wa <= 32'd60) begin
            mb[wa[5:0]]         = ld[31:24];
            mb[wa[5:0] + 6'd1]  = ld[23:16];
            mb[wa[5:0] + 6'd2]  = ld[15:8];
            mb[wa[5:0] + 6'd3]  = ld[7:0];
        end
        if (rv && exp_ready) begin
            m_valid = 1'b1;
            m_mis   = (p % 4) != 0;
            m_rng   = p > 32'd60;
            m_instr = (m_mis || m_rng) ? 32'h0 : mword(p);
        end else if (rr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] p);
        step(1'b1, p, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 32'h0, 1'b1, 1'b1, a, d);
    endtask

    task automatic drain();
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] words [4];
        logic [31:0] p;
        logic [31:0] la;
        words[0] = 32'h84a0_1b12;
        words[1] = 32'h4400_bb22;
        words[2] = 32'h3000_ccaa;
        words[3] = 32'h5511_29dd;
        for (int i = 0; i < 64; i++) mb[i] = 8'h00;

        // Reset, clear length and a fetch from the top word.
        apply_reset(2);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h1);
        wait_clear();
        fetch(32'h3C);
        drain();

        // Program load then full-throughput fetches.
        for (int i = 0; i < 4; i++) load(32'(i * 4), words[i]);
        for (int i = 0; i < 4; i++) fetch(32'(i * 4));
        drain();
        check("word_c", m_instr, words[3]);

        // Fault flags.
        fetch(32'h6);
        fetch(32'h40);
        fetch(32'h3E);
        fetch(32'h8000_0000);
        drain();

        // Load beats fetch, then read-after-load, then an out-of-range load.
        step(1'b1, 32'h8, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
        fetch(32'h8);
        drain();
        check("deadbeef", m_instr, 32'hDEAD_BEEF);
        load(32'h40, 32'h1234_5678);
        for (int i = 0; i < 16; i++) fetch(32'(i * 4));
        drain();

        // Backpressure: response held for three cycles, then consumed with a same-cycle accept.
        fetch(32'h4);
        repeat (3) step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0);
        drain();

        // Reset during cycle 5 of the clear sequence.
        apply_reset(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_clr_busy", 32'(bus.busy), 32'h1);
        end
        @(posedge clk);
        #1;
        apply_reset(1);
        wait_clear();
        fetch(32'h8);
        drain();

        // Reset with a response pending.
        load(32'hC, 32'hCAFE_F00D);
        step(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        apply_reset(1);
        @(negedge clk);
        check("rst_pend_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_pend_busy", 32'(bus.busy), 32'h1);
        @(posedge clk);
        #1;
        apply_reset(1);
        wait_clear();
        fetch(32'hC);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 9))
                0:       p = 32'($urandom_range(0, 63));
                1:       p = 32'h40 + 32'($urandom_range(0, 15)) * 32'd4;
                2:       p = $urandom | 32'h8000_0000;
                default: p = 32'($urandom_range(0, 15)) * 32'd4;
            endcase
            la = ($urandom_range(0, 4) == 0) ? 32'h40 + 32'($urandom_range(0, 15)) * 32'd4
                                             : 32'($urandom_range(0, 15)) * 32'd4;
            step($urandom_range(0, 3) != 0, p, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 5) == 0, la, $urandom);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
